// File: rtl/hw_demux_buf.sv
// 1-to-4 demux with a one-entry buffer per channel; 1-cycle latency; din_ready_o low when target is full and not draining.
// Optional HW_DEMUX_AUTOSEL_EN replaces sel_i with an internal round-robin pointer.
module hw_demux_buf #(
    parameter int DW = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [DW-1:0]   din_i,
    input  logic [1:0]      sel_i,
    input  logic            din_valid_i,
    output logic            din_ready_o,
    output logic [4*DW-1:0] dout_o,
    output logic [3:0]      dout_valid_o,
    input  logic [3:0]      dout_ready_i
);

    logic [3:0][DW-1:0] data_q, data_d;
    logic [3:0]         full_q, full_d;
    logic [1:0]         ch;
    logic               acc;

`ifdef HW_DEMUX_AUTOSEL_EN
    logic [1:0] ptr_q, ptr_d;

    assign ch    = ptr_q;
    assign ptr_d = acc ? ptr_q + 2'd1 : ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= 2'd0;
        else         ptr_q <= ptr_d;
    end
`else
    assign ch = sel_i;
`endif

    assign din_ready_o  = ~full_q[ch] | dout_ready_i[ch];
    assign acc          = din_valid_i & din_ready_o;
    assign dout_o       = data_q;
    assign dout_valid_o = full_q;

    // A write to the target wins over its drain, giving bubble-free refill.
    always_comb begin
        data_d = data_q;
        full_d = full_q & ~dout_ready_i;
        if (acc) begin
            data_d[ch] = din_i;
            full_d[ch] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            full_q <= '0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

endmodule

// File: tb/tb_hw_demux_buf.sv
module tb_hw_demux_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  din;
    logic [1:0]  sel;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready;

    int total = 0;
    int bad   = 0;

    hw_demux_buf #(.DW(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .din_i(din), .sel_i(sel),
        .din_valid_i(din_valid), .din_ready_o(din_ready), .dout_o(dout),
        .dout_valid_o(dout_valid), .dout_ready_i(dout_ready)
    );

    always #5 clk = ~clk;

    // Reference model: four mailboxes, each either empty or holding one word.
    logic [2:0] m_data [4];
    logic       m_full [4];
    int         m_ptr;
    logic       s_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_data[k] = 3'd0;
            m_full[k] = 1'b0;
        end
        m_ptr = 0;
    endtask

    function automatic int target(input logic [1:0] s);
`ifdef HW_DEMUX_AUTOSEL_EN
        return m_ptr;
`else
        return int'(s);
`endif
    endfunction

    function automatic logic [11:0] m_dout();
        logic [11:0] r = '0;
        for (int k = 0; k < 4; k++) r = r | (12'(m_data[k]) << (3 * k));
        return r;
    endfunction

    function automatic logic [3:0] m_valid();
        logic [3:0] r = '0;
        for (int k = 0; k < 4; k++) r[k] = m_full[k];
        return r;
    endfunction

    // Drive one cycle, compare against the model before and after the edge.
    task automatic step(input logic [2:0] d, input logic [1:0] s, input logic v, input logic [3:0] r);
        int  t;
        logic ok;
        din = d; sel = s; din_valid = v; dout_ready = r;
        #1;
        t  = target(s);
        ok = !m_full[t] || r[t];
        s_rdy = din_ready;
        chk("model_rdy", 32'(din_ready), 32'(ok));
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (v && ok && t == k) begin
                m_data[k] = d;
                m_full[k] = 1'b1;
            end else if (m_full[k] && r[k]) begin
                m_full[k] = 1'b0;
            end
        end
        if (v && ok) m_ptr = (m_ptr + 1) % 4;
        #1;
        chk("model_valid", 32'(dout_valid), 32'(m_valid()));
        chk("model_dout", 32'(dout), 32'(m_dout()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din = '0; sel = '0; din_valid = 1'b0; dout_ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  d;
        logic [1:0]  s;
        logic        v;
        logic [3:0]  r;
        logic        rdy;
        logic [3:0]  vv;
        logic [11:0] dd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [2:0] rd;
        logic [1:0] rs;
        logic       rv;
        logic       pending;

        tbl[0]  = '{3'h2, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 12'h002};
        tbl[1]  = '{3'h1, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 12'h00A};
        tbl[2]  = '{3'h6, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0011, 12'h00A};
        tbl[3]  = '{3'h6, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0011, 12'h032};
        tbl[4]  = '{3'h0, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 12'h032};
        tbl[5]  = '{3'h3, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 12'h033};
        tbl[6]  = '{3'h4, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 12'h023};
        tbl[7]  = '{3'h5, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 12'h163};
        tbl[8]  = '{3'h7, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 12'hF63};
        tbl[9]  = '{3'h0, 2'd0, 1'b0, 4'b1010, 1'b0, 4'b0101, 12'hF63};
        tbl[10] = '{3'h1, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b0101, 12'hF63};
        tbl[11] = '{3'h2, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0111, 12'hF53};
        tbl[12] = '{3'h0, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 12'h153};

        do_reset();
        chk("reset_valid", 32'(dout_valid), 32'h0);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_rdy", 32'(din_ready), 32'h1);

`ifndef HW_DEMUX_AUTOSEL_EN
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].r);
            chk($sformatf("tbl%0d_rdy", i), 32'(s_rdy), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(dout_valid), 32'(tbl[i].vv));
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dd));
        end
`else
        // Round robin ignores sel and wraps 3 -> 0.
        for (int i = 0; i < 5; i++) begin
            step(3'(i + 1), 2'd2, 1'b1, 4'b1111);
            chk($sformatf("rr%0d_valid", i), 32'(dout_valid), 32'(4'b0001 << (i % 4)));
            chk($sformatf("rr%0d_data", i), 32'((dout >> (3 * (i % 4))) & 12'h7), 32'(i + 1));
        end
        do_reset();
        for (int i = 0; i < 4; i++) step(3'(i + 1), 2'd0, 1'b1, 4'b0000);
        step(3'h5, 2'd0, 1'b1, 4'b0001);
        chk("rr_fill_valid", 32'(dout_valid), 32'hF);
        for (int i = 0; i < 2; i++) begin
            step(3'h6, 2'd0, 1'b1, 4'b0000);
            chk("rr_stall_rdy", 32'(s_rdy), 32'h0);
            chk("rr_stall_ch1", 32'((dout >> 3) & 12'h7), 32'h2);
        end
        step(3'h6, 2'd0, 1'b1, 4'b0010);
        chk("rr_refill_rdy", 32'(s_rdy), 32'h1);
        chk("rr_refill_ch1", 32'((dout >> 3) & 12'h7), 32'h6);
        chk("rr_refill_valid", 32'(dout_valid), 32'hF);
        step(3'h1, 2'd0, 1'b1, 4'b0000);
        chk("rr_fill_valid2", 32'(dout_valid), 32'hF);
`endif

        // Asynchronous reset between edges while all channels are full.
        chk("pre_arst_valid", 32'(dout_valid), 32'hF);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'h0);
        chk("arst_dout", 32'(dout), 32'h0);
        model_reset();
        din_valid = 1'b0; dout_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_arst_rdy", 32'(din_ready), 32'h1);

        // Random traffic; the producer holds its offer until accepted.
        pending = 1'b0;
        rd = '0; rs = '0; rv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                rd = 3'($urandom);
                rs = 2'($urandom);
                rv = ($urandom_range(0, 3) != 0);
            end
            step(rd, rs, rv, 4'($urandom));
            pending = rv && !s_rdy;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
